data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder (memory side) of the core's data-memory handshake: accepts one read/write
//  request from the control path, optionally inserts wait states, performs the
//  byte-enabled access, and returns a one-cycle data_ack with read data.
//  Sits between control and the data-memory storage, replacing the zero-wait direct path.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words of storage
//  LATENCY      2              wait cycles between accept and ack (0 allowed)
//  BASE_ADDR    32'h00000000   byte address of word 0
// PORTS
//  clk               in   1   clock, all state on rising edge
//  reset             in   1   asynchronous, active-low reset (asserted when 0)
//  data_addr         in   32  byte address of request; [1:0] ignored (word aligned)
//  data_write        in   32  write data
//  data_write_byte   in   4   byte enables; bit i -> data_write[8i+7:8i]
//  data_read_valid   in   1   read request
//  data_write_valid  in   1   write request
//  data_ready        out  1   responder can accept a request this cycle
//  data_ack          out  1   one-cycle completion pulse
//  data_read         out  32  read data, valid while data_ack=1, held until next ack
//  data_error        out  1   pulses with data_ack when the address was out of range
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, counter=0, data_ack=0, data_error=0,
//    data_read=32'h0, data_ready=1. Storage contents are NOT cleared.
//  - data_ready = (state==IDLE). Request = data_read_valid | data_write_valid.
//  - Accept at edge E0 when IDLE & request: latch addr, wdata, byte enables, rd/wr flags.
//  - States: IDLE -> WAIT (LATENCY>0, cnt<=LATENCY-1) or IDLE -> ACK (LATENCY==0, access at E0).
//    WAIT: cnt==0 -> perform access, go ACK; else cnt--. ACK: data_ack=1, -> IDLE next edge.
//  - Ack timing: data_ack registered high at edge E0+LATENCY, exactly one cycle wide.
//    Max throughput: one request per LATENCY+2 cycles.
//  - Address: idx=(addr-BASE_ADDR)>>2; in range iff addr>=BASE_ADDR and idx<DEPTH_WORDS.
//  - Write: only enabled bytes of word idx updated at the access edge; data_write_byte=0
//    is a legal no-op write that still acks.
//  - Read: data_read = full 32-bit word regardless of byte enables.
//  - Read and write both asserted: write performed, data_read returns post-merge word.
//  - Out of range: write dropped, data_read=32'h0, data_error=1 with data_ack.
//  - Request inputs ignored outside IDLE; requester holds them stable until data_ack,
//    and a request still asserted in the IDLE cycle after ack is a NEW request.
//  - Reset mid-operation: return to IDLE, pending access dropped (no write), no ack.
// STRUCTURE
//  - Package riscv_mem_pkg: enum resp_state_t {IDLE, WAIT, ACK}, WORD_W=32, BE_W=4.
//  - Sub-module byte_ram: DEPTH_WORDS x 32 synchronous RAM, 4 byte-write enables,
//    registered read port; data_mem_responder holds FSM, counter, range check.
// TESTING
//  - Reset: reset=0 mid-WAIT of a write to 0x10 -> no ack, word 0x10 unchanged, ready=1.
//  - Write 0xDEADBEEF to 0x20, be=4'hF, LATENCY=2 -> ack at E0+2; read 0x20 -> 0xDEADBEEF.
//  - Write 0x000000AA to 0x20, be=4'b0001 -> read 0x20 returns 0xDEADBEAA.
//  - Read 0x23 -> same word as 0x20 (low bits ignored); ready=0 from E0+1 until ack clears.
//  - Read addr 4*DEPTH_WORDS -> data_read=0, data_error=1 with ack; write there -> no side effect.
//  - LATENCY=0 build: back-to-back requests held high -> ack every 2nd cycle, data correct.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory responder and its storage.
package riscv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Responder handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_t;

    // Replace the enabled bytes of old_word with the matching bytes of new_word
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. A read on the same edge as a write returns the merged word.
module byte_ram
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] merged;

    // Word as it will look after this edge's write (old word when not writing)
    always_comb begin
        merged = mem[addr];
        if (we) begin
            merged = merge_bytes(mem[addr], wdata, be);
        end else begin
            merged = mem[addr];
        end
    end

    // Storage update: only enabled bytes are written; contents survive reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port, held between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {WORD_W{1'b0}};
        end else if (en) begin
            rdata <= merged;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory handshake: accepts one
// request, waits LATENCY cycles, performs the byte-enabled access and returns
// a one-cycle ack with read data and an out-of-range flag.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data_addr,
    input  logic [WORD_W-1:0] data_write,
    input  logic [BE_W-1:0]   data_write_byte,
    input  logic              data_read_valid,
    input  logic              data_write_valid,
    output logic              data_ready,
    output logic              data_ack,
    output logic [WORD_W-1:0] data_read,
    output logic              data_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD    = CW'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [31:0]   DEPTH_LIMIT = 32'(DEPTH_WORDS);

    resp_state_t       state;
    resp_state_t       state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;

    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              wr_q;
    logic              err_q;

    logic              request;
    logic              do_access;
    logic [31:0]       acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_wr;
    logic [31:0]       word_off;
    logic              in_range;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign request = data_read_valid | data_write_valid;

    // Next-state and access-strobe logic of the handshake FSM
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (LATENCY == 0) begin
                        do_access  = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == {CW{1'b0}}) begin
                    do_access  = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - CW'(1'b1);
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= {CW{1'b0}};
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request when it is accepted in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'h0000_0000;
            wdata_q <= {WORD_W{1'b0}};
            be_q    <= {BE_W{1'b0}};
            wr_q    <= 1'b0;
        end else if ((state == IDLE) && request) begin
            addr_q  <= data_addr;
            wdata_q <= data_write;
            be_q    <= data_write_byte;
            wr_q    <= data_write_valid;
        end
    end

    // With zero latency the access happens on the accept edge, so use live inputs
    always_comb begin
        if (LATENCY == 0) begin
            acc_addr  = data_addr;
            acc_wdata = data_write;
            acc_be    = data_write_byte;
            acc_wr    = data_write_valid;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_wr    = wr_q;
        end
    end

    // Word index relative to the base; low address bits are dropped
    always_comb begin
        word_off = (acc_addr - BASE_ADDR) >> 32'd2;
        in_range = (acc_addr >= BASE_ADDR) && (word_off < DEPTH_LIMIT);
    end

    assign ram_we = do_access & acc_wr & in_range;

    byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .rst_n(reset),
        .en   (do_access),
        .we   (ram_we),
        .be   (acc_be),
        .addr (word_off[AW-1:0]),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    // Handshake outputs: ack/error pulse on the access edge, ready mirrors IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_ack   <= 1'b0;
            data_error <= 1'b0;
            err_q      <= 1'b0;
            data_ready <= 1'b1;
        end else begin
            data_ack   <= do_access;
            data_error <= do_access & ~in_range;
            if (do_access) begin
                err_q <= ~in_range;
            end
            data_ready <= (state_next == IDLE);
        end
    end

    // Read data is the RAM's held output, forced to zero after an out-of-range access
    assign data_read = err_q ? {WORD_W{1'b0}} : ram_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench: unit 0 is a LATENCY=2 / 1024-word responder,
// unit 1 a LATENCY=0 / 16-word responder used for back-to-back traffic.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] rdata;
    logic [1:0][3:0]  be;
    logic [1:0]       rv, wv, ready, ack, err;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .reset(reset), .data_addr(addr[0]), .data_write(wdata[0]),
        .data_write_byte(be[0]), .data_read_valid(rv[0]), .data_write_valid(wv[0]),
        .data_ready(ready[0]), .data_ack(ack[0]), .data_read(rdata[0]), .data_error(err[0]));

    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .reset(reset), .data_addr(addr[1]), .data_write(wdata[1]),
        .data_write_byte(be[1]), .data_read_valid(rv[1]), .data_write_valid(wv[1]),
        .data_ready(ready[1]), .data_ack(ack[1]), .data_read(rdata[1]), .data_error(err[1]));

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          chk;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [2][1024];
    exp_t        mon_e;
    bit          mon_got;
    logic [1:0]  prev_ack = 2'b00;

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic int depth_of(input int u);
        return (u == 0) ? 1024 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops one expected response
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ack[u]) begin
                checks++;
                mon_got = 1'b0;
                if (u == 0 && q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    mon_got = 1'b1;
                end else if (u == 1 && q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    mon_got = 1'b1;
                end
                if (!mon_got) begin
                    errors++;
                    $display("FAIL unexpected_ack unit%0d: got ack=1 expected no ack", u);
                end else if (err[u] !== mon_e.err || (mon_e.chk && rdata[u] !== mon_e.data)) begin
                    errors++;
                    $display("FAIL ack_resp unit%0d: got data=%h err=%b expected data=%h err=%b",
                             u, rdata[u], err[u], mon_e.data, mon_e.err);
                end
                checks++;
                if (prev_ack[u]) begin
                    errors++;
                    $display("FAIL ack_width unit%0d: got ack high 2 cycles expected 1", u);
                end
            end
            prev_ack[u] = ack[u];
        end
    end

    // Compute the expected response from the memory model and push it
    task automatic predict(input int u, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b, output exp_t e);
        bit          inr;
        int          idx;
        logic [31:0] mask;
        inr = ((a >> 2) < 32'(depth_of(u)));
        idx = inr ? int'(a >> 2) : 0;
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
        if (inr && wr) model[u][idx] = (model[u][idx] & ~mask) | (wd & mask);
        e.err  = !inr;
        e.data = inr ? model[u][idx] : 32'h0;
        e.chk  = rd || !inr;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // One complete request: wait ready, drive, check latency/ready/hold
    task automatic do_req(input int u, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b);
        exp_t e;
        int   k;
        k = 0;
        while (ready[u] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_idle", 32'(ready[u]), 32'h1);
        addr[u] = a; wdata[u] = wd; be[u] = b; rv[u] = rd; wv[u] = wr;
        predict(u, rd, wr, a, wd, b, e);
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!ack[u] && k < 20) begin
            chk("ready_busy", 32'(ready[u]), 32'h0);
            @(negedge clk);
            k++;
        end
        chk("ack_latency", 32'(k), 32'(lat_of(u)));
        chk("ready_in_ack", 32'(ready[u]), 32'h0);
        rv[u] = 1'b0; wv[u] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack[u]), 32'h0);
        if (e.chk) chk("read_hold", rdata[u], e.data);
    endtask

    initial begin
        exp_t        e;
        int          n;
        int          r;
        logic [31:0] a;
        addr = '0; wdata = '0; be = '0; rv = '0; wv = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 32'(ready[u]), 32'h1);
            chk("rst_ack", 32'(ack[u]), 32'h0);
            chk("rst_err", 32'(err[u]), 32'h0);
            chk("rst_rdata", rdata[u], 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) begin
            do_req(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
            do_req(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
        end

        // Directed cases on the latency-2 unit
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("dir_deadbeef", rdata[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h000000AA, 4'b0001);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("dir_byte_merge", rdata[0], 32'hDEADBEAA);
        do_req(0, 1'b1, 1'b0, 32'h23, 32'h0, 4'h0);
        chk("dir_low_bits", rdata[0], 32'hDEADBEAA);
        do_req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
        do_req(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        do_req(0, 1'b1, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0);
        do_req(0, 1'b1, 1'b1, 32'h28, 32'h11223344, 4'b1100);
        do_req(0, 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF);
        do_req(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
        do_req(0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0);

        // Reset in the middle of a write's wait: no ack, no write, ready again
        while (ready[0] !== 1'b1) @(negedge clk);
        addr[0] = 32'h10; wdata[0] = ~model[0][4]; be[0] = 4'hF; wv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wv[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_ready", 32'(ready[0]), 32'h1);
            chk("midrst_ack", 32'(ack[0]), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Randomized traffic on both units
        for (int i = 0; i < 60; i++) begin
            for (int u = 0; u < 2; u++) begin
                r = $urandom_range(0, 9);
                if (r == 0) a = 32'(depth_of(u) * 4) + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
                else        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                r = $urandom_range(0, 2);
                do_req(u, (r != 1), (r != 0), a, $urandom, 4'($urandom_range(0, 15)));
            end
        end

        // Zero-latency unit with the read request held high across acks
        while (ready[1] !== 1'b1) @(negedge clk);
        n = 0;
        addr[1] = 32'h0; rv[1] = 1'b1;
        predict(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, e);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("b2b_ack_pattern", 32'(ack[1]), (c % 2 == 0) ? 32'h1 : 32'h0);
            if (ack[1]) begin
                n++;
                if (n < 4) begin
                    addr[1] = 32'(n * 4);
                    predict(1, 1'b1, 1'b0, 32'(n * 4), 32'h0, 4'h0, e);
                end else begin
                    rv[1] = 1'b0;
                end
            end
        end
        rv[1] = 1'b0;

        repeat (4) @(negedge clk);
        chk("pending_unit0", 32'(q0.size()), 32'h0);
        chk("pending_unit1", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so a stuck handshake still ends the run
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
